cdc_handshake_src: RTL and testbench

Source-side controller for a 4-phase req/ack CDC handshake carrying a DATA_W-bit word to another clock domain.
- Accepts words on a valid/ready interface and holds each word stable on xfer_data for the whole handshake.
- Drives a registered level xfer_req and synchronizes the destination's raw ack into clk.
- Sequences the full req-up/ack-up/req-down/ack-down cycle, with an optional watchdog timeout.
- Sits in the source domain of any multi-bit CDC path, in front of a destination-side capture block.

---
 rtl/cdc_pkg.sv | 15 +
 rtl/cdc_bit_sync_rst.sv | 23 ++
 rtl/cdc_handshake_src.sv | 130 +++++++++++++
 tb/tb_cdc_handshake_src.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// Shared types and helpers for the source side of the 4-phase req/ack CDC handshake.
package cdc_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        RELEASE   = 2'd2,
        ERR_DRAIN = 2'd3
    } hs_state_e;

    function automatic int unsigned tmo_cnt_w(input int unsigned cycles);
        return (cycles == 0) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/cdc_bit_sync_rst.sv
// Multi-flop single-bit synchronizer, asynchronously reset to 0.
module cdc_bit_sync_rst #(
    parameter int unsigned SYNC_DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_in,
    output logic q_out
);

    logic [SYNC_DEPTH-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_DEPTH-2:0], d_in};
        end
    end

    assign q_out = chain[SYNC_DEPTH-1];

endmodule

// File: rtl/cdc_handshake_src.sv
// Source-side 4-phase req/ack controller: holds one word on xfer_data per handshake,
// synchronizes the returning ack and optionally flags a stalled destination.
module cdc_handshake_src
    import cdc_pkg::*;
#(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned SYNC_DEPTH     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic [DATA_W-1:0] xfer_data,
    output logic              xfer_req,
    input  logic              xfer_ack_async,
    output logic              xfer_done,
    output logic              busy,
    output logic              timeout_err,
    input  logic              err_clr
);

    hs_state_e state;
    hs_state_e state_next;
    logic      ack_s;
    logic      req_next;
    logic      done_next;
    logic      load_data;
    logic      err_set;
    logic      tmo_hit;

    cdc_bit_sync_rst #(
        .SYNC_DEPTH(SYNC_DEPTH)
    ) u_ack_sync (
        .clk  (clk),
        .rst  (rst),
        .d_in (xfer_ack_async),
        .q_out(ack_s)
    );

    // A stale ack in IDLE must finish its falling phase before a new word is taken.
    assign s_ready = (state == IDLE) && !ack_s;
    assign busy    = (state != IDLE);

    always_comb begin
        state_next = state;
        req_next   = 1'b0;
        done_next  = 1'b0;
        load_data  = 1'b0;
        err_set    = 1'b0;
        case (state)
            IDLE: begin
                if (s_valid && s_ready) begin
                    load_data  = 1'b1;
                    req_next   = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (ack_s) begin
                    done_next  = 1'b1;
                    state_next = RELEASE;
                end else if (tmo_hit) begin
                    err_set    = 1'b1;
                    state_next = ERR_DRAIN;
                end else begin
                    req_next = 1'b1;
                end
            end
            RELEASE: begin
                // A release timeout only flags the error; ERR_DRAIN still waits for ack low.
                if (!ack_s) begin
                    state_next = IDLE;
                end else if (tmo_hit) begin
                    err_set    = 1'b1;
                    state_next = ERR_DRAIN;
                end
            end
            ERR_DRAIN: begin
                if (!ack_s) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            xfer_req    <= 1'b0;
            xfer_done   <= 1'b0;
            xfer_data   <= '0;
            timeout_err <= 1'b0;
        end else begin
            state     <= state_next;
            xfer_req  <= req_next;
            xfer_done <= done_next;
            if (load_data) begin
                xfer_data <= s_data;
            end
            if (err_set) begin
                timeout_err <= 1'b1;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end
        end
    end

    if (TIMEOUT_CYCLES > 0) begin : g_wdog
        localparam int unsigned CNT_W = tmo_cnt_w(TIMEOUT_CYCLES);
        logic [CNT_W-1:0] cnt;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= '0;
            end else if (state_next != state) begin
                cnt <= '0;
            end else if (((state == REQ) || (state == RELEASE)) && (cnt != '1)) begin
                cnt <= cnt + CNT_W'(1);
            end
        end

        assign tmo_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    end else begin : g_no_wdog
        assign tmo_hit = 1'b0;
    end

endmodule

// File: tb/tb_cdc_handshake_src.sv
// Directed bench for cdc_handshake_src: vector table for one full handshake plus corner sequences.
module tb_cdc_handshake_src;

    localparam int unsigned SD  = 2;
    localparam int unsigned TMO = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic [7:0] xfer_data;
    logic       xfer_req;
    logic       ack;
    logic       xfer_done;
    logic       busy;
    logic       timeout_err;
    logic       err_clr;

    int checks = 0;
    int errors = 0;

    logic [7:0] words [4];

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       a;
        logic       c;
        logic       e_rdy;
        logic       e_req;
        logic [7:0] e_data;
        logic       e_done;
        logic       e_busy;
        logic       e_err;
    } vec_t;

    vec_t tbl [9];

    always #5 clk = ~clk;

    cdc_handshake_src #(
        .DATA_W        (8),
        .SYNC_DEPTH    (SD),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .xfer_data     (xfer_data),
        .xfer_req      (xfer_req),
        .xfer_ack_async(ack),
        .xfer_done     (xfer_done),
        .busy          (busy),
        .timeout_err   (timeout_err),
        .err_clr       (err_clr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Acts as the destination: ack follows req directly; words[0..n-1] offered in order.
    task automatic run_words(input int n, input int budget, input string tag);
        int   acc_idx  = 0;
        int   done_idx = 0;
        bit   acc;
        logic prev_req;
        logic [7:0] prev_data;
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (done_idx == n && acc_idx == n && !busy) break;
            s_valid   = (acc_idx < n);
            s_data    = (acc_idx < n) ? words[acc_idx] : 8'h00;
            ack       = xfer_req;
            acc       = s_valid && s_ready;
            prev_req  = xfer_req;
            prev_data = xfer_data;
            step();
            if (acc) begin
                check($sformatf("%s accept data %0d", tag, acc_idx), xfer_data, words[acc_idx]);
                check($sformatf("%s accept req %0d", tag, acc_idx), xfer_req, 1'b1);
                acc_idx++;
            end else if (prev_req && xfer_req) begin
                check($sformatf("%s data stable", tag), xfer_data, prev_data);
            end
            if (xfer_done) begin
                if (done_idx < n)
                    check($sformatf("%s done word %0d", tag, done_idx), xfer_data, words[done_idx]);
                done_idx++;
            end
        end
        s_valid = 1'b0;
        ack     = 1'b0;
        check($sformatf("%s done count", tag), done_idx, n);
        check($sformatf("%s accept count", tag), acc_idx, n);
        check($sformatf("%s idle at end", tag), busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL global time limit: got timeout expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        int done_seen;

        tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};

        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = 8'h00;
        ack     = 1'b0;
        err_clr = 1'b0;
        repeat (2) step();
        rst = 1'b0;

        check("reset s_ready", s_ready, 1'b1);
        check("reset xfer_req", xfer_req, 1'b0);
        check("reset xfer_data", xfer_data, 8'h00);
        check("reset xfer_done", xfer_done, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset timeout_err", timeout_err, 1'b0);

        for (int i = 0; i < 9; i++) begin
            s_valid = tbl[i].v;
            s_data  = tbl[i].d;
            ack     = tbl[i].a;
            err_clr = tbl[i].c;
            step();
            check($sformatf("row%0d s_ready", i), s_ready, tbl[i].e_rdy);
            check($sformatf("row%0d xfer_req", i), xfer_req, tbl[i].e_req);
            check($sformatf("row%0d xfer_data", i), xfer_data, tbl[i].e_data);
            check($sformatf("row%0d xfer_done", i), xfer_done, tbl[i].e_done);
            check($sformatf("row%0d busy", i), busy, tbl[i].e_busy);
            check($sformatf("row%0d timeout_err", i), timeout_err, tbl[i].e_err);
        end

        words[0] = 8'h01;
        words[1] = 8'h02;
        words[2] = 8'h03;
        run_words(3, 200, "b2b");

        // Watchdog: no ack ever arrives.
        done_seen = 0;
        s_valid = 1'b1;
        s_data  = 8'h3C;
        ack     = 1'b0;
        step();
        s_valid = 1'b0;
        check("tmo accept req", xfer_req, 1'b1);
        check("tmo accept data", xfer_data, 8'h3C);
        for (int i = 1; i < 16; i++) begin
            step();
            if (xfer_done) done_seen++;
            check($sformatf("tmo req held %0d", i), xfer_req, 1'b1);
        end
        check("tmo err before expiry", timeout_err, 1'b0);
        step();
        if (xfer_done) done_seen++;
        check("tmo req dropped", xfer_req, 1'b0);
        check("tmo err set", timeout_err, 1'b1);
        check("tmo drain busy", busy, 1'b1);
        step();
        if (xfer_done) done_seen++;
        check("tmo back to idle", busy, 1'b0);
        check("tmo err sticky", timeout_err, 1'b1);
        check("tmo no done", done_seen, 0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("tmo err cleared", timeout_err, 1'b0);
        words[0] = 8'hC3;
        run_words(1, 50, "after_clr");

        // Set and clear in the same cycle: set must win.
        err_clr = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'h99;
        step();
        s_valid = 1'b0;
        repeat (15) step();
        check("setclr err before", timeout_err, 1'b0);
        step();
        check("setclr set wins", timeout_err, 1'b1);
        err_clr = 1'b0;
        step();
        check("setclr err holds", timeout_err, 1'b1);
        check("setclr idle", busy, 1'b0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;

        // Stale ack held across reset blocks acceptance.
        rst = 1'b1;
        ack = 1'b1;
        step();
        rst = 1'b0;
        step();
        step();
        check("stale s_ready low", s_ready, 1'b0);
        s_valid = 1'b1;
        s_data  = 8'h11;
        repeat (3) step();
        check("stale no accept busy", busy, 1'b0);
        check("stale no accept req", xfer_req, 1'b0);
        s_valid = 1'b0;
        ack     = 1'b0;
        step();
        check("stale s_ready after 1", s_ready, 1'b0);
        step();
        check("stale s_ready after 2", s_ready, 1'b1);

        // Asynchronous reset in the middle of REQ.
        s_valid = 1'b1;
        s_data  = 8'h77;
        step();
        s_valid = 1'b0;
        check("arst pre req", xfer_req, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("arst req", xfer_req, 1'b0);
        check("arst busy", busy, 1'b0);
        check("arst data", xfer_data, 8'h00);
        #1 rst = 1'b0;
        step();
        words[0] = 8'h5A;
        run_words(1, 50, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
